// File: rtl/mem_bus_responder.sv
// Memory-side responder for the RV32I data bus: internal 64-word RAM, external
// wait-stated ROM port, one-cycle MemReady/MemError completion per request.
module mem_bus_responder #(
    parameter int unsigned ROM_WAIT = 1,
    parameter logic [31:0] ROM_LAST = 32'h0000_03FF,
    parameter logic [31:0] RAM_BASE = 32'h0000_0400,
    parameter logic [31:0] RAM_LAST = 32'h0000_04FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [3:0]  ByteEn,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemError,
    output logic        ROM_CS,
    output logic [7:0]  ROM_Addr,
    input  logic [31:0] ROM_Data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROM_WAIT,
        S_RESP
    } state_t;

    state_t      r_state, w_state_nx;
    logic [3:0]  r_cnt, w_cnt_nx;
    logic [31:0] r_rdata, w_rdata_nx;
    logic        r_ready, w_ready_nx;
    logic        r_err, w_err_nx;
    logic        r_cs, w_cs_nx;
    logic [7:0]  r_rom_addr, w_rom_addr_nx;
    logic        w_ram_we;

    logic [31:0] r_mem [0:63];

    logic        w_aligned, w_ram_hit, w_rom_hit;
    logic [5:0]  w_ram_idx;

    // RAM_BASE sits on a 256-byte boundary, so Addr[7:2] is the word index.
    assign w_aligned = (Addr[1:0] == 2'b00);
    assign w_ram_hit = w_aligned && (Addr >= RAM_BASE) && (Addr <= RAM_LAST);
    assign w_rom_hit = w_aligned && (Addr <= ROM_LAST);
    assign w_ram_idx = Addr[7:2];

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_rdata_nx    = 32'h0;
        w_ready_nx    = 1'b0;
        w_err_nx      = 1'b0;
        w_cs_nx       = r_cs;
        w_rom_addr_nx = r_rom_addr;
        w_ram_we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MemReq) begin
                    if (w_ram_hit) begin
                        w_ready_nx = 1'b1;
                        w_state_nx = S_RESP;
                        if (MemWrite) w_ram_we   = !reset;
                        else          w_rdata_nx = r_mem[w_ram_idx];
                    end else if (w_rom_hit && !MemWrite) begin
                        w_cs_nx       = 1'b1;
                        w_rom_addr_nx = Addr[9:2];
                        w_cnt_nx      = 4'(ROM_WAIT);
                        w_state_nx    = S_ROM_WAIT;
                    end else begin
                        w_ready_nx = 1'b1;
                        w_err_nx   = 1'b1;
                        w_state_nx = S_RESP;
                    end
                end
            end
            S_ROM_WAIT: begin
                // Data is sampled on the last cycle ROM_CS is high.
                if (r_cnt == 4'd0) begin
                    w_rdata_nx = ROM_Data;
                    w_ready_nx = 1'b1;
                    w_cs_nx    = 1'b0;
                    w_state_nx = S_RESP;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_rdata    <= 32'h0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_cs       <= 1'b0;
            r_rom_addr <= 8'h0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_rdata    <= w_rdata_nx;
            r_ready    <= w_ready_nx;
            r_err      <= w_err_nx;
            r_cs       <= w_cs_nx;
            r_rom_addr <= w_rom_addr_nx;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ByteEn[i]) r_mem[w_ram_idx][8*i +: 8] <= WriteData[8*i +: 8];
            end
        end
    end

    assign ReadData = r_rdata;
    assign MemReady = r_ready;
    assign MemError = r_err;
    assign ROM_CS   = r_cs;
    assign ROM_Addr = r_rom_addr;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder against a memory-map reference model.
module tb_mem_bus_responder;

    localparam int RW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReq, MemWrite;
    logic [31:0] Addr, WriteData;
    logic [3:0]  ByteEn;
    logic [31:0] ReadData;
    logic        MemReady, MemError, ROM_CS;
    logic [7:0]  ROM_Addr;
    logic [31:0] ROM_Data;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_ram [0:63];

    always #5 clk = ~clk;

    mem_bus_responder #(.ROM_WAIT(RW)) u_dut (
        .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .ByteEn(ByteEn),
        .ReadData(ReadData), .MemReady(MemReady), .MemError(MemError),
        .ROM_CS(ROM_CS), .ROM_Addr(ROM_Addr), .ROM_Data(ROM_Data)
    );

    function automatic logic [31:0] rom_f(input logic [7:0] w);
        if (w == 8'h04) return 32'h1234_5678;
        return {w, ~w, w ^ 8'hA5, 8'h3C + w};
    endfunction

    // External ROM: garbage whenever not selected, so a late sample shows up.
    assign ROM_Data = ROM_CS ? rom_f(ROM_Addr) : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
        bit          is_ram, is_rom, is_err, done;
        int          lat_exp, cyc, bad_cs, bad_rd;
        logic [31:0] rd_exp, nw;

        is_ram = (a[1:0] == 2'b00) && (a >= 32'h400) && (a <= 32'h4FF);
        is_rom = (a[1:0] == 2'b00) && (a <= 32'h3FF) && !wr;
        is_err = !is_ram && !is_rom;
        lat_exp = is_rom ? 2 + RW : 1;
        rd_exp  = 32'h0;
        if (is_ram && !wr) rd_exp = m_ram[a[7:2]];
        if (is_rom)        rd_exp = rom_f(a[9:2]);

        @(negedge clk);
        chk("idle_outs", {29'h0, MemReady, MemError, ROM_CS}, 32'h0);
        MemReq = 1'b1; MemWrite = wr; Addr = a; WriteData = wd; ByteEn = be;
        @(posedge clk);
        #1;
        // The request was latched in C0; later input wiggles must be ignored.
        MemWrite = 1'($urandom); Addr = $urandom; WriteData = $urandom;
        ByteEn = 4'($urandom);

        cyc = 0; done = 0; bad_cs = 0; bad_rd = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (is_rom && cyc <= 1 + RW) begin
                if (ROM_CS !== 1'b1 || ROM_Addr !== a[9:2]) bad_cs++;
            end else if (ROM_CS !== 1'b0) bad_cs++;
            if (MemReady === 1'b1) done = 1;
            else if (ReadData !== 32'h0) bad_rd++;
        end
        MemReq = 1'b0;
        chk("latency", cyc, lat_exp);
        chk("error", {31'h0, MemError}, {31'h0, is_err});
        if (!wr || is_err) chk("rdata", ReadData, rd_exp);
        chk("rom_cs", bad_cs, 0);
        chk("rdata_idle", bad_rd, 0);

        if (is_ram && wr) begin
            nw = m_ram[a[7:2]];
            for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
            m_ram[a[7:2]] = nw;
        end
    endtask

    initial begin
        logic [31:0] a;
        int          region;
        bit          seen_rdy, seen_cs;

        reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; Addr = 32'h0;
        WriteData = 32'h0; ByteEn = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, MemReady}, 32'h0);
        chk("rst_error", {31'h0, MemError}, 32'h0);
        chk("rst_cs", {31'h0, ROM_CS}, 32'h0);
        chk("rst_rdata", ReadData, 32'h0);
        chk("rst_raddr", {24'h0, ROM_Addr}, 32'h0);

        for (int i = 0; i < 64; i++) do_req(1'b1, 32'h400 + 32'(i * 4), $urandom, 4'hF);

        do_req(1'b1, 32'h404, 32'hDEAD_BEEF, 4'hF);
        do_req(1'b0, 32'h404, 32'h0, 4'h0);
        chk("dir_deadbeef", m_ram[1], 32'hDEAD_BEEF);
        do_req(1'b1, 32'h404, 32'h0000_00AA, 4'b0001);
        do_req(1'b0, 32'h404, 32'h0, 4'hF);
        do_req(1'b1, 32'h404, 32'h5555_5555, 4'b0000);
        do_req(1'b0, 32'h404, 32'h0, 4'h0);
        chk("dir_beaa", m_ram[1], 32'hDEAD_BEAA);
        do_req(1'b0, 32'h010, 32'h0, 4'h0);
        do_req(1'b0, 32'h500, 32'h0, 4'h0);
        do_req(1'b0, 32'h402, 32'h0, 4'h0);
        do_req(1'b1, 32'h000, 32'h1111_1111, 4'hF);
        do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
        do_req(1'b0, 32'h3FC, 32'h0, 4'h0);
        do_req(1'b0, 32'h400, 32'h0, 4'h0);
        do_req(1'b0, 32'h4FC, 32'h0, 4'h0);
        do_req(1'b1, 32'h4FC, 32'hCAFE_F00D, 4'b1010);
        do_req(1'b0, 32'h4FC, 32'h0, 4'h0);

        for (int n = 0; n < 300; n++) begin
            region = int'($urandom_range(0, 5));
            case (region)
                0, 1: begin
                    a = 32'h400 + 32'($urandom_range(0, 63) * 4);
                    do_req(1'($urandom), a, $urandom, 4'($urandom));
                end
                2, 3: begin
                    a = 32'($urandom_range(0, 255) * 4);
                    do_req($urandom_range(0, 3) == 0, a, $urandom, 4'($urandom));
                end
                4: begin
                    a = 32'($urandom_range(0, 32'h4FF));
                    if (a[1:0] == 2'b00) a = a | 32'h1;
                    do_req(1'($urandom), a, $urandom, 4'($urandom));
                end
                default: begin
                    a = $urandom;
                    if (a <= 32'h4FF) a = a + 32'h500;
                    do_req(1'($urandom), a, $urandom, 4'($urandom));
                end
            endcase
        end

        // Reset during C2 of a ROM load aborts it without a completion.
        @(negedge clk);
        MemReq = 1'b1; MemWrite = 1'b0; Addr = 32'h020; ByteEn = 4'h0;
        @(negedge clk);
        chk("abort_cs_c1", {31'h0, ROM_CS}, 32'h1);
        @(negedge clk);
        reset = 1'b1; MemReq = 1'b0;
        @(negedge clk);
        chk("abort_cs", {31'h0, ROM_CS}, 32'h0);
        chk("abort_rdy", {31'h0, MemReady}, 32'h0);
        reset = 1'b0;
        seen_rdy = 0; seen_cs = 0;
        repeat (6) begin
            @(negedge clk);
            if (MemReady === 1'b1) seen_rdy = 1;
            if (ROM_CS === 1'b1) seen_cs = 1;
        end
        chk("abort_no_rdy", {31'h0, seen_rdy}, 32'h0);
        chk("abort_no_cs", {31'h0, seen_cs}, 32'h0);
        do_req(1'b0, 32'h404, 32'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
